// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the front-panel time-setting controller.
package time_set_ctrl_pkg;

  localparam int HOURS_W   = 5;
  localparam int MIN_W     = 6;
  localparam int HOURS_MAX = 24;
  localparam int MIN_MAX   = 60;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_e;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_HOURS = 2'd1;
  localparam logic [1:0] FIELD_MINS  = 2'd2;

endpackage

// File: rtl/time_set_ctrl_button_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, level debounce,
// one-cycle press pulse on the debounced rising edge, and the held level.
module button_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic held_o
);

  // Arming needs more low samples than the two stale zeros the reset
  // synchronizer can supply, so a button held through reset never presses.
  localparam int ARM_N = DEBOUNCE + 2;
  localparam int CW    = $clog2(ARM_N + 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    armed_d = armed_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (!armed_q) begin
      if (!s2_q) begin
        if (cnt_q == CW'(ARM_N - 1)) armed_d = 1'b1;
        else                         cnt_d   = cnt_q + 1'b1;
      end
    end else if (s2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = s2_q;
        press_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;
  assign held_o  = level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting FSM: RUN -> SET_H -> SET_M with shadow edit, auto-repeat,
// idle abort, blink indication and a one-cycle commit load.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int TIMEOUT      = 3000,
  parameter int BLINK_HALF   = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [HOURS_W-1:0] hours_in,
  input  logic [MIN_W-1:0]   minutes_in,
  output logic               load,
  output logic [HOURS_W-1:0] hours_out,
  output logic [MIN_W-1:0]   minutes_out,
  output logic               clear_secs,
  output logic [1:0]         field,
  output logic               blink
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int IW   = $clog2(TIMEOUT + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);

  logic mode_p, inc_p, inc_held, mode_held_unused;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode (
    .clk(clk), .rst(rst), .btn_i(btn_mode), .press_o(mode_p), .held_o(mode_held_unused)
  );
  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc (
    .clk(clk), .rst(rst), .btn_i(btn_inc), .press_o(inc_p), .held_o(inc_held)
  );

  state_e             state_q, state_d;
  logic [HOURS_W-1:0] hrs_q, hrs_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic               load_q, load_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               rep_on_q, rep_on_d, rep_first_q, rep_first_d;
  logic [RW-1:0]      rep_cnt_q, rep_cnt_d, rep_tgt;
  logic [BW-1:0]      bcnt_q, bcnt_d, show_q, show_d;
  logic               blink_q, blink_d;
  logic               rep_p, inc_evt, inc_ok;

  // rep_cnt_q holds the number of cycles since the last press/repeat pulse.
  assign rep_tgt = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
  assign rep_p   = rep_on_q & inc_held & (rep_cnt_q == rep_tgt);
  assign inc_evt = inc_p | rep_p;
  assign inc_ok  = inc_evt & ~mode_p;

  always_comb begin
    rep_on_d    = rep_on_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    if (!inc_held) begin
      rep_on_d  = 1'b0;
      rep_cnt_d = '0;
    end else if (inc_p) begin
      rep_on_d    = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = RW'(1);
    end else if (rep_p) begin
      rep_first_d = 1'b0;
      rep_cnt_d   = RW'(1);
    end else if (rep_on_q) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hrs_d   = hrs_q;
    min_d   = min_q;
    load_d  = 1'b0;
    idle_d  = '0;
    case (state_q)
      SET_H: begin
        if (mode_p) state_d = SET_M;
        else if (inc_ok)
          hrs_d = (hrs_q == HOURS_W'(HOURS_MAX - 1)) ? '0 : hrs_q + 1'b1;
      end
      SET_M: begin
        if (mode_p) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_ok) begin
          min_d = (min_q == MIN_W'(MIN_MAX - 1)) ? '0 : min_q + 1'b1;
        end
      end
      default: begin
        if (mode_p) begin
          state_d = SET_H;
          hrs_d   = hours_in;
          min_d   = minutes_in;
        end
      end
    endcase
    // Idle abort only applies in the setting states and only without events.
    if (state_q != RUN && !mode_p && !inc_evt) begin
      if (idle_q == IW'(TIMEOUT - 1)) state_d = RUN;
      else                            idle_d  = idle_q + 1'b1;
    end
  end

  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b0;
    show_d  = '0;
    if (state_q != RUN) begin
      if (bcnt_q == BW'(BLINK_HALF - 1)) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        blink_d = blink_q;
      end
      if (inc_ok)            show_d = BW'(BLINK_HALF);
      else if (show_q != '0) show_d = show_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      hrs_q       <= '0;
      min_q       <= '0;
      load_q      <= 1'b0;
      idle_q      <= '0;
      rep_on_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b0;
      show_q      <= '0;
    end else begin
      state_q     <= state_d;
      hrs_q       <= hrs_d;
      min_q       <= min_d;
      load_q      <= load_d;
      idle_q      <= idle_d;
      rep_on_q    <= rep_on_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      show_q      <= show_d;
    end
  end

  always_comb begin
    case (state_q)
      SET_H:   field = FIELD_HOURS;
      SET_M:   field = FIELD_MINS;
      default: field = FIELD_NONE;
    endcase
  end

  assign load        = load_q;
  assign clear_secs  = load_q;
  assign hours_out   = hrs_q;
  assign minutes_out = min_q;
  assign blink       = (state_q != RUN) & (blink_q | (show_q != '0));

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed + randomized bench for time_set_ctrl against a shadow-time model.
module tb_time_set_ctrl;

  localparam int TIMEOUT      = 3000;
  localparam int REPEAT_DELAY = 50;
  localparam int REPEAT_RATE  = 10;

  logic       clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] hours_in = '0;
  logic [5:0] minutes_in = '0;
  logic       load, clear_secs, blink;
  logic [4:0] hours_out;
  logic [5:0] minutes_out;
  logic [1:0] field;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hours_in(hours_in), .minutes_in(minutes_in), .load(load),
    .hours_out(hours_out), .minutes_out(minutes_out), .clear_secs(clear_secs),
    .field(field), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int load_cnt = 0, cs_bad = 0, ld_h = -1, ld_m = -1, post_h = -1, post_m = -1;
  logic load_prev = 1'b0;

  always @(negedge clk) begin
    if (clear_secs !== load) cs_bad <= cs_bad + 1;
    if (load_prev === 1'b1) begin
      post_h <= int'(hours_out);
      post_m <= int'(minutes_out);
    end
    if (load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      ld_h     <= int'(hours_out);
      ld_m     <= int'(minutes_out);
    end
    load_prev <= load;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit m, input bit i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    tick(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(12);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".load"}, 32'(load), 0);
    chk({tag, ".clear_secs"}, 32'(clear_secs), 0);
    chk({tag, ".hours"}, 32'(hours_out), 0);
    chk({tag, ".minutes"}, 32'(minutes_out), 0);
    chk({tag, ".field"}, 32'(field), 0);
    chk({tag, ".blink"}, 32'(blink), 0);
  endtask

  // Increments produced by holding inc for d debounced cycles.
  function automatic int incs_for_hold(input int d);
    if (d - 1 < REPEAT_DELAY) return 1;
    return 2 + (d - 1 - REPEAT_DELAY) / REPEAT_RATE;
  endfunction

  initial begin
    int mh, mm, n, d;
    logic [3:0] bounce;

    rst = 1'b1;
    tick(3);
    chk_zero("reset");
    rst = 1'b0;
    tick(10);

    // Bouncy inc in RUN: ignored.
    bounce = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      btn_inc = bounce[b];
      tick(1);
    end
    btn_inc = 1'b1;
    tick(10);
    btn_inc = 1'b0;
    tick(12);
    chk("run_inc.field", 32'(field), 0);
    chk("run_inc.hours", 32'(hours_out), 0);
    chk("run_inc.blink", 32'(blink), 0);

    // Bouncy mode: exactly one press, latency 2+DEBOUNCE plus one registered step.
    hours_in = 5'd23;
    minutes_in = 6'd59;
    for (int b = 0; b < 4; b++) begin
      btn_mode = bounce[b];
      tick(1);
    end
    btn_mode = 1'b1;
    tick(5);
    chk("mode_latency.early", 32'(field), 0);
    tick(1);
    chk("mode_latency.field", 32'(field), 1);
    tick(2);
    btn_mode = 1'b0;
    tick(12);
    mh = 23;
    mm = 59;
    chk("enter.hours", 32'(hours_out), 32'(mh));
    chk("enter.minutes", 32'(minutes_out), 32'(mm));
    chk("enter.field_single_press", 32'(field), 1);

    press(0, 1, 8);
    mh = (mh + 1) % 24;
    chk("hours_wrap", 32'(hours_out), 32'(mh));
    press(1, 0, 8);
    chk("to_set_m.field", 32'(field), 2);
    press(0, 1, 8);
    mm = (mm + 1) % 60;
    chk("minutes_wrap", 32'(minutes_out), 32'(mm));
    chk("inc_shown.blink", 32'(blink), 1);

    // Commit: load exactly one cycle after the press pulse.
    btn_mode = 1'b1;
    tick(5);
    chk("commit.no_early_load", 32'(load), 0);
    tick(1);
    chk("commit.load", 32'(load), 1);
    chk("commit.clear_secs", 32'(clear_secs), 1);
    chk("commit.hours", 32'(hours_out), 32'(mh));
    chk("commit.minutes", 32'(minutes_out), 32'(mm));
    tick(1);
    chk("commit.load_drop", 32'(load), 0);
    chk("commit.field", 32'(field), 0);
    btn_mode = 1'b0;
    tick(12);
    chk("commit.load_count", 32'(load_cnt), 1);
    chk("commit.post_hours", 32'(post_h), 32'(mh));
    chk("commit.post_minutes", 32'(post_m), 32'(mm));

    // Random hours edits then auto-repeat on minutes.
    hours_in = 5'($urandom_range(0, 23));
    minutes_in = 6'd10;
    press(1, 0, 8);
    mh = int'(hours_in);
    mm = 10;
    chk("enter2.hours", 32'(hours_out), 32'(mh));
    n = $urandom_range(1, 5);
    for (int k = 0; k < n; k++) press(0, 1, 8);
    mh = (mh + n) % 24;
    chk("rand_inc.hours", 32'(hours_out), 32'(mh));
    press(1, 0, 8);
    chk("enter2.minutes", 32'(minutes_out), 32'(mm));
    press(0, 1, 80);
    mm = (mm + incs_for_hold(80)) % 60;
    chk("repeat_80", 32'(minutes_out), 32'(mm));
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(20, 140);
      press(0, 1, d);
      mm = (mm + incs_for_hold(d)) % 60;
      chk("repeat_rand", 32'(minutes_out), 32'(mm));
    end
    press(1, 0, 8);
    chk("commit2.load_count", 32'(load_cnt), 2);
    chk("commit2.hours", 32'(ld_h), 32'(mh));
    chk("commit2.minutes", 32'(ld_m), 32'(mm));

    // Blink phase and idle abort in SET_H.
    hours_in = 5'($urandom_range(0, 23));
    btn_mode = 1'b1;
    tick(6);
    chk("abort.enter", 32'(field), 1);
    tick(2);
    btn_mode = 1'b0;
    tick(8);
    chk("blink.phase0", 32'(blink), 0);
    tick(25);
    chk("blink.phase1", 32'(blink), 1);
    tick(25);
    chk("blink.phase2", 32'(blink), 0);
    tick(TIMEOUT - 1 - 60);
    chk("abort.before", 32'(field), 1);
    tick(1);
    chk("abort.field", 32'(field), 0);
    chk("abort.blink", 32'(blink), 0);
    tick(2);
    chk("abort.no_load", 32'(load_cnt), 2);

    // Mode and inc in the same cycle: mode wins.
    hours_in = 5'($urandom_range(0, 23));
    minutes_in = 6'($urandom_range(0, 59));
    press(1, 0, 8);
    mh = int'(hours_in);
    mm = int'(minutes_in);
    press(1, 1, 8);
    chk("same_cycle.field", 32'(field), 2);
    chk("same_cycle.hours", 32'(hours_out), 32'(mh));
    press(0, 1, 8);
    mm = (mm + 1) % 60;
    chk("set_m.inc", 32'(minutes_out), 32'(mm));

    // Reset mid-edit.
    rst = 1'b1;
    tick(1);
    chk_zero("mid_reset");
    rst = 1'b0;
    tick(10);
    chk("mid_reset.no_load", 32'(load_cnt), 2);

    // Button held through reset release must not press.
    btn_mode = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    chk("held_reset.field", 32'(field), 0);
    btn_mode = 1'b0;
    tick(12);
    press(1, 0, 8);
    chk("held_reset.repress", 32'(field), 1);

    chk("clear_secs_eq_load", 32'(cs_bad), 0);
    chk("final.load_count", 32'(load_cnt), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel time-setting controller that sits directly upstream of the clock counters. It debounces two raw push-buttons, mode and increment, and runs a RUN → SET_H → SET_M state machine. In the setting states it edits shadow copies of hours and minutes, and on commit it issues a one-cycle load of the new time into the hour and minute counters with seconds cleared. It also produces a blink/field indication so the display stage can flash the field being edited.

## Interface
Parameters:
- DEBOUNCE, default 3: consecutive stable synchronized samples needed to accept a button level change.
- REPEAT_DELAY, default 50: cycles inc must stay held after its press before auto-repeat starts.
- REPEAT_RATE, default 10: cycles between auto-repeat increments.
- TIMEOUT, default 3000: idle cycles in a setting state before aborting to RUN.
- BLINK_HALF, default 25: cycles per blink half-period.

Ports:
- clk  in  1  system clock, the same clock that drives the centisecond counter.
- rst  in  1  reset; synchronous, active-high.
- btn_mode  in  1  raw mode button, active-high, asynchronous, bouncy.
- btn_inc  in  1  raw increment button, active-high, asynchronous, bouncy.
- hours_in  in  5  live hours from the clock, 0–23.
- minutes_in  in  6  live minutes from the clock, 0–59.
- load  out  1  one-cycle commit strobe to the clock counters.
- hours_out  out  5  shadow hours; valid whenever load=1.
- minutes_out  out  6  shadow minutes; valid whenever load=1.
- clear_secs  out  1  equals load; clears seconds and centiseconds.
- field  out  2  field being edited: 0 = none, 1 = hours, 2 = minutes.
- blink  out  1  blank request for the edited field; always 0 in RUN.

## Operation
Input conditioning:
- Each button passes through a 2-flop synchronizer.
- The debounced level changes only after the synchronized level has differed from it for DEBOUNCE consecutive cycles.
- A press is a one-cycle pulse emitted in the cycle the debounced level rises 0→1.

Auto-repeat:
- While inc stays debounced-high, the first repeat pulse comes REPEAT_DELAY cycles after the press pulse.
- After that, one repeat pulse every REPEAT_RATE cycles.
- Repeat pulses are treated exactly like press pulses.

States:
- RUN: on a mode press, copy hours_in and minutes_in into the shadows and go to SET_H. Inc presses are ignored.
- SET_H: an inc press advances the hours shadow modulo 24 (23 → 0). A mode press goes to SET_M.
- SET_M: an inc press advances the minutes shadow modulo 60 (59 → 0). A mode press goes to RUN and asserts load and clear_secs for exactly one cycle.
- In SET_H or SET_M, TIMEOUT cycles with no press or repeat pulse send the FSM back to RUN with no load (abort). Every press or repeat resets the idle counter.

Rules:
- If mode and inc pulses arrive in the same cycle, mode wins and the inc pulse is discarded.
- field is 1 in SET_H, 2 in SET_M, 0 in RUN.
- blink toggles every BLINK_HALF cycles while in a setting state. It is forced to 1 ("shown") for BLINK_HALF cycles after any inc, so the changed value stays visible.
- Shadow registers hold their value in RUN. hours_out and minutes_out show the shadows at all times.
- Shadow increments wrap at the limits; values are never compared against cmp-1 style widths.

## Timing
- Reset value of every output is 0. Reset also sets state RUN, clears the shadows, debounced levels, and all counters.
- Reset takes effect mid-edit with no load pulse.
- Raw button edge to press pulse: 2 + DEBOUNCE cycles, provided the input stays stable.
- Press pulse to a state change or shadow update: 1 cycle, registered.
- load asserts in the cycle after the SET_M mode press pulse and lasts exactly one cycle.
- hours_out and minutes_out are stable in the load cycle and in the cycle after it.
- A button held through reset release produces no press pulse until it is released and pressed again.

## Structure
- The shared package holds:
  - the state enum {RUN, SET_H, SET_M};
  - the field encoding constants;
  - HOURS_W=5, MIN_W=6, HOURS_MAX=24, MIN_MAX=60.
- One sub-module, button_debounce (synchronizer, debounce counter, press pulse, held level), is instantiated twice.
- Auto-repeat, timeout and blink logic live in time_set_ctrl.

## Test plan
All scenarios use default parameters.
- Reset, then pulse btn_inc for 1 cycle with bounce (1,0,1,0,1 held) → exactly one inc pulse, 5 cycles after the last edge. In RUN it causes no output change and field stays 0.
- hours_in=23, minutes_in=59; press mode → field=1 and hours_out=23. Press inc → hours_out=0. Press mode → field=2. Press inc → minutes_out=0. Press mode → one load cycle with hours_out=0, minutes_out=0, clear_secs=1; field=0 the cycle after.
- In SET_M with minutes shadow 10, hold inc for 80 cycles → presses at offset 0, +50, +60, +70 → minutes_out=14.
- Enter SET_H, then idle 3000 cycles → field returns to 0 and load never asserts.
- Mode and inc pulses in the same cycle while in SET_H → state becomes SET_M and the hours shadow is unchanged.
- Assert rst during SET_M after edits → the next cycle has every output 0 and state RUN, and load never pulses.
